hamming_uart_tx: RTL

Serializes 7-bit Hamming(7,4) codewords into asynchronous UART frames on a single `tx` line. The block sits directly downstream of the Hamming encoder and consumes its `code_out`/`valid_out` pair. A one-entry holding buffer lets the encoder deliver the next codeword while the current frame is still shifting out. The result is back-to-back frames with no idle gap.

---
 rtl/hamming_uart_tx.sv | 132 +++++++++++++
 1 files changed

// File: rtl/hamming_uart_tx.sv
// UART transmitter for 7-bit Hamming codewords: start bit, 7 data bits LSB first, one stop bit.
// A one-entry holding buffer lets the next codeword arrive mid-frame so frames run back to back.
module hamming_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [6:0] code_in,
    input  logic       valid_in,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       overrun
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      idx_q;
    logic [6:0]      shift_q;
    logic [6:0]      hold_data_q;
    logic            hold_valid_q;
    logic            hold_valid_d;
    logic            ready_q;
    logic            tx_q;
    logic            busy_q;
    logic            overrun_q;

    logic            cnt_last;
    logic            load;
    logic            accept;

    // Buffer handshake and frame-load decision; ready is registered, so a load edge never accepts.
    always_comb begin
        cnt_last     = (cnt_q == CNT_LAST);
        accept       = valid_in && ready_q;
        load         = hold_valid_q && ena &&
                       ((state_q == IDLE) || ((state_q == STOP) && cnt_last));
        hold_valid_d = hold_valid_q;
        if (accept) begin
            hold_valid_d = 1'b1;
        end else if (load) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            hold_valid_q <= hold_valid_d;
            ready_q      <= !hold_valid_d;
            overrun_q    <= valid_in && !ready_q;
            if (accept) begin
                hold_data_q <= code_in;
            end

            if (load) begin
                state_q <= START;
                shift_q <= hold_data_q;
                cnt_q   <= '0;
                idx_q   <= '0;
                tx_q    <= 1'b0;
                busy_q  <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        cnt_q <= '0;
                    end
                    START: begin
                        if (cnt_last) begin
                            state_q <= DATA;
                            cnt_q   <= '0;
                            idx_q   <= '0;
                            tx_q    <= shift_q[0];
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    DATA: begin
                        if (cnt_last) begin
                            cnt_q <= '0;
                            if (idx_q == 3'd6) begin
                                state_q <= STOP;
                                tx_q    <= 1'b1;
                            end else begin
                                // Present the next bit while shifting it into position 0.
                                shift_q <= {1'b0, shift_q[6:1]};
                                idx_q   <= idx_q + 3'd1;
                                tx_q    <= shift_q[1];
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    STOP: begin
                        if (cnt_last) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign ready   = ready_q;
    assign tx      = tx_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule
